// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one external combinational barrel shifter.
// Grants at most one request per cycle and keeps one response register per port.
module shift_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_a,
    input  logic [4:0]  i_req0_shamt,
    input  logic [1:0]  i_req0_type,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_a,
    input  logic [4:0]  i_req1_shamt,
    input  logic [1:0]  i_req1_type,
    output logic        o_resp0_valid,
    input  logic        i_resp0_ready,
    output logic [31:0] o_resp0_data,
    output logic        o_resp1_valid,
    input  logic        i_resp1_ready,
    output logic [31:0] o_resp1_data,
    output logic [31:0] o_sh_a,
    output logic [4:0]  o_sh_shamt,
    output logic [1:0]  o_sh_type,
    input  logic [31:0] i_sh_r,
    output logic        o_prio_ptr
);

    // Valid/ready: a transfer happens on any rising edge where valid && ready.
    // A requester that is not granted keeps valid and operands stable.
    // Ready depends on both valids and slot state, never on the shifter result.

    logic        r_prio_ptr;
    logic        r_resp0_valid;
    logic        r_resp1_valid;
    logic [31:0] r_resp0_data;
    logic [31:0] r_resp1_data;

    logic w_slot_free0;
    logic w_slot_free1;
    logic w_elig0;
    logic w_elig1;
    logic w_prio;
    logic w_grant0;
    logic w_grant1;

    // A slot draining this cycle can be refilled in the same cycle.
    assign w_slot_free0 = !r_resp0_valid || i_resp0_ready;
    assign w_slot_free1 = !r_resp1_valid || i_resp1_ready;
    assign w_elig0      = i_rst_n && i_req0_valid && w_slot_free0;
    assign w_elig1      = i_rst_n && i_req1_valid && w_slot_free1;

    assign w_prio   = FIXED_PRIORITY ? 1'b0 : r_prio_ptr;
    assign w_grant0 = w_elig0 && (!w_elig1 || !w_prio);
    assign w_grant1 = w_elig1 && (!w_elig0 || w_prio);

    assign o_req0_ready  = w_grant0;
    assign o_req1_ready  = w_grant1;
    assign o_resp0_valid = r_resp0_valid;
    assign o_resp1_valid = r_resp1_valid;
    assign o_resp0_data  = r_resp0_data;
    assign o_resp1_data  = r_resp1_data;
    assign o_prio_ptr    = r_prio_ptr;

    // Idle drive is a pass-through of zero so the shifter never toggles needlessly.
    always_comb begin
        o_sh_a     = 32'd0;
        o_sh_shamt = 5'd0;
        o_sh_type  = 2'b11;
        if (w_grant0) begin
            o_sh_a     = i_req0_a;
            o_sh_shamt = i_req0_shamt;
            o_sh_type  = i_req0_type;
        end else if (w_grant1) begin
            o_sh_a     = i_req1_a;
            o_sh_shamt = i_req1_shamt;
            o_sh_type  = i_req1_type;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prio_ptr    <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_data  <= 32'd0;
            r_resp1_data  <= 32'd0;
        end else begin
            if (w_grant0) begin
                r_resp0_valid <= 1'b1;
                r_resp0_data  <= i_sh_r;
            end else if (i_resp0_ready) begin
                r_resp0_valid <= 1'b0;
            end

            if (w_grant1) begin
                r_resp1_valid <= 1'b1;
                r_resp1_data  <= i_sh_r;
            end else if (i_resp1_ready) begin
                r_resp1_valid <= 1'b0;
            end

            // After a grant to port 0 the pointer favours port 1, and vice versa.
            if (!FIXED_PRIORITY && (w_grant0 || w_grant1)) begin
                r_prio_ptr <= w_grant0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are compared against a port-level reference model of slots and grants.
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [1:0]  resp_ready;
    logic [31:0] req_a     [2];
    logic [4:0]  req_shamt [2];
    logic [1:0]  req_type  [2];

    // Index 0 = round-robin instance, index 1 = fixed-priority instance.
    logic [1:0]  rdy      [2];
    logic [1:0]  rv       [2];
    logic [31:0] rd       [2][2];
    logic [31:0] sh_a     [2];
    logic [4:0]  sh_s     [2];
    logic [1:0]  sh_t     [2];
    logic [31:0] sh_r     [2];
    logic        prio_dbg [2];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                              input logic [1:0] t);
        case (t)
            2'b00:   return a >> s;
            2'b01:   return a << s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return a;
        endcase
    endfunction

    assign sh_r[0] = ref_shift(sh_a[0], sh_s[0], sh_t[0]);
    assign sh_r[1] = ref_shift(sh_a[1], sh_s[1], sh_t[1]);

    shift_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req_valid[0]), .o_req0_ready(rdy[0][0]),
        .i_req0_a(req_a[0]), .i_req0_shamt(req_shamt[0]), .i_req0_type(req_type[0]),
        .i_req1_valid(req_valid[1]), .o_req1_ready(rdy[0][1]),
        .i_req1_a(req_a[1]), .i_req1_shamt(req_shamt[1]), .i_req1_type(req_type[1]),
        .o_resp0_valid(rv[0][0]), .i_resp0_ready(resp_ready[0]), .o_resp0_data(rd[0][0]),
        .o_resp1_valid(rv[0][1]), .i_resp1_ready(resp_ready[1]), .o_resp1_data(rd[0][1]),
        .o_sh_a(sh_a[0]), .o_sh_shamt(sh_s[0]), .o_sh_type(sh_t[0]), .i_sh_r(sh_r[0]),
        .o_prio_ptr(prio_dbg[0])
    );

    shift_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req_valid[0]), .o_req0_ready(rdy[1][0]),
        .i_req0_a(req_a[0]), .i_req0_shamt(req_shamt[0]), .i_req0_type(req_type[0]),
        .i_req1_valid(req_valid[1]), .o_req1_ready(rdy[1][1]),
        .i_req1_a(req_a[1]), .i_req1_shamt(req_shamt[1]), .i_req1_type(req_type[1]),
        .o_resp0_valid(rv[1][0]), .i_resp0_ready(resp_ready[0]), .o_resp0_data(rd[1][0]),
        .o_resp1_valid(rv[1][1]), .i_resp1_ready(resp_ready[1]), .o_resp1_data(rd[1][1]),
        .o_sh_a(sh_a[1]), .o_sh_shamt(sh_s[1]), .o_sh_type(sh_t[1]), .i_sh_r(sh_r[1]),
        .o_prio_ptr(prio_dbg[1])
    );

    // Reference model: per-instance result slots and priority holder.
    logic [1:0]  m_v    [2] = '{2'b00, 2'b00};
    logic [31:0] m_d    [2][2] = '{'{32'd0, 32'd0}, '{32'd0, 32'd0}};
    logic        m_prio [2] = '{1'b0, 1'b0};
    logic [1:0]  mg;

    function automatic logic [1:0] exp_grant(input int k);
        logic e0;
        logic e1;
        e0 = rst_n && req_valid[0] && (!m_v[k][0] || resp_ready[0]);
        e1 = rst_n && req_valid[1] && (!m_v[k][1] || resp_ready[1]);
        if (e0 && e1) return (k == 1 || !m_prio[k]) ? 2'b01 : 2'b10;
        return {e1, e0};
    endfunction

    function automatic logic [38:0] exp_drive(input int k);
        logic [1:0] g;
        g = exp_grant(k);
        if (g[0]) return {req_a[0], req_shamt[0], req_type[0]};
        if (g[1]) return {req_a[1], req_shamt[1], req_type[1]};
        return {32'd0, 5'd0, 2'b11};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mg = exp_grant(k);
            if (!rst_n) begin
                m_v[k] <= 2'b00;
                m_d[k][0] <= 32'd0;
                m_d[k][1] <= 32'd0;
                m_prio[k] <= 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (mg[i]) begin
                        m_v[k][i] <= 1'b1;
                        m_d[k][i] <= ref_shift(req_a[i], req_shamt[i], req_type[i]);
                    end else if (resp_ready[i]) begin
                        m_v[k][i] <= 1'b0;
                    end
                end
                if (k == 0 && mg != 2'b00) m_prio[k] <= mg[0];
            end
        end
    end

    task automatic rand_op(input int p);
        req_a[p]     = $urandom;
        req_shamt[p] = 5'($urandom_range(0, 31));
        req_type[p]  = 2'($urandom_range(0, 3));
    endtask

    task automatic set_op(input int p, input logic [31:0] a, input logic [4:0] s,
                          input logic [1:0] t);
        req_a[p] = a;
        req_shamt[p] = s;
        req_type[p] = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        resp_ready = 2'b11;
        rand_op(0);
        rand_op(1);
        @(negedge clk);
        #1;
        checks++;
        if (rdy[0] !== 2'b00 || rdy[1] !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b expected 00/00", rdy[0], rdy[1]);
        end
        checks++;
        if (rv[0] !== 2'b00 || rv[1] !== 2'b00 || rd[0][0] !== 32'd0 || rd[0][1] !== 32'd0) begin
            errors++;
            $display("FAIL reset_resp: got valid %b data %h/%h expected 00 0/0",
                     rv[0], rd[0][0], rd[0][1]);
        end
        checks++;
        if ({sh_a[0], sh_s[0], sh_t[0]} !== {32'd0, 5'd0, 2'b11} || prio_dbg[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_drive: got %h/%0d/%b prio %b expected 0/0/11 prio 0",
                     sh_a[0], sh_s[0], sh_t[0], prio_dbg[0]);
        end
        rst_n = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 2'b01;
        resp_ready = 2'b11;
        set_op(0, 32'h8000_0001, 5'd4, 2'b01);
        #1;
        checks++;
        if (rdy[0] !== 2'b01 || {sh_a[0], sh_s[0], sh_t[0]} !== {32'h8000_0001, 5'd4, 2'b01}) begin
            errors++;
            $display("FAIL single_grant: got ready %b drive %h/%0d/%b expected 01 80000001/4/01",
                     rdy[0], sh_a[0], sh_s[0], sh_t[0]);
        end
        @(negedge clk);
        set_op(0, 32'hDEAD_BEEF, 5'd7, 2'b11);
        #1;
        checks++;
        if (rv[0][0] !== 1'b1 || rd[0][0] !== 32'h0000_0010) begin
            errors++;
            $display("FAIL single_left: got %b/%h expected 1/00000010", rv[0][0], rd[0][0]);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (rv[0][0] !== 1'b1 || rd[0][0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_pass: got %b/%h expected 1/deadbeef", rv[0][0], rd[0][0]);
        end
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 0, 1};
        int prev_p = 0;
        logic [31:0] prev_exp = 32'd0;
        logic [1:0] exp_g;
        do_reset();
        rand_op(0);
        rand_op(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c > 0) rand_op(prev_p);
            req_valid = (c < 4) ? 2'b11 : 2'b00;
            resp_ready = 2'b11;
            #1;
            if (c < 4) begin
                exp_g = (order[c] == 0) ? 2'b01 : 2'b10;
                checks++;
                if (rdy[0] !== exp_g) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got %b expected %b", c, rdy[0], exp_g);
                end
            end
            if (c > 0) begin
                checks++;
                if ({rv[0][prev_p], rd[0][prev_p]} !== {1'b1, prev_exp}) begin
                    errors++;
                    $display("FAIL rr_resp[%0d]: port %0d got %b/%h expected 1/%h",
                             c, prev_p, rv[0][prev_p], rd[0][prev_p], prev_exp);
                end
            end
            if (c < 4) begin
                prev_p = order[c];
                prev_exp = ref_shift(req_a[prev_p], req_shamt[prev_p], req_type[prev_p]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] p1_exp = 32'd0;
        do_reset();
        @(negedge clk);
        req_valid = 2'b01;
        resp_ready = 2'b10;
        rand_op(0);
        held = ref_shift(req_a[0], req_shamt[0], req_type[0]);
        #1;
        checks++;
        if (rdy[0] !== 2'b01) begin
            errors++;
            $display("FAIL bp_fill: got %b expected 01", rdy[0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 2'b11;
            rand_op(1);
            #1;
            checks++;
            if (rdy[0] !== 2'b10 || {rv[0][0], rd[0][0]} !== {1'b1, held}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ready %b slot0 %b/%h expected 10 1/%h",
                         c, rdy[0], rv[0][0], rd[0][0], held);
            end
            if (c > 0) begin
                checks++;
                if (rd[0][1] !== p1_exp) begin
                    errors++;
                    $display("FAIL bp_port1[%0d]: got %h expected %h", c, rd[0][1], p1_exp);
                end
            end
            p1_exp = ref_shift(req_a[1], req_shamt[1], req_type[1]);
        end
    endtask

    task automatic test_drain_refill();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        do_reset();
        @(negedge clk);
        req_valid = 2'b01;
        resp_ready = 2'b00;
        rand_op(0);
        exp_a = ref_shift(req_a[0], req_shamt[0], req_type[0]);
        @(negedge clk);
        resp_ready = 2'b01;
        rand_op(0);
        exp_b = ref_shift(req_a[0], req_shamt[0], req_type[0]);
        #1;
        checks++;
        if (rdy[0][0] !== 1'b1 || {rv[0][0], rd[0][0]} !== {1'b1, exp_a}) begin
            errors++;
            $display("FAIL refill_accept: got ready %b slot %b/%h expected 1 1/%h",
                     rdy[0][0], rv[0][0], rd[0][0], exp_a);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_valid = 2'b00;
            resp_ready = 2'b00;
            #1;
            checks++;
            if ({rv[0][0], rd[0][0]} !== {1'b1, exp_b}) begin
                errors++;
                $display("FAIL refill_new[%0d]: got %b/%h expected 1/%h",
                         c, rv[0][0], rd[0][0], exp_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_valid = 2'b11;
            resp_ready = 2'b00;
            rand_op(0);
            rand_op(1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rv[0] !== 2'b11 || rdy[0] !== 2'b00 || rdy[1] !== 2'b00) begin
            errors++;
            $display("FAIL midrst_during: got valid %b ready %b/%b expected 11 00/00",
                     rv[0], rdy[0], rdy[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 2'b11;
        #1;
        checks++;
        if (rv[0] !== 2'b00 || rd[0][0] !== 32'd0 || rd[0][1] !== 32'd0) begin
            errors++;
            $display("FAIL midrst_clear: got valid %b data %h/%h expected 00 0/0",
                     rv[0], rd[0][0], rd[0][1]);
        end
        checks++;
        if (rdy[0] !== 2'b01) begin
            errors++;
            $display("FAIL midrst_first: got %b expected 01", rdy[0]);
        end
    endtask

    task automatic test_fixed_priority();
        logic [31:0] prev0 = 32'd0;
        logic [31:0] p1_exp;
        do_reset();
        rand_op(1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 2'b11;
            resp_ready = 2'b11;
            rand_op(0);
            #1;
            checks++;
            if (rdy[1] !== 2'b01) begin
                errors++;
                $display("FAIL fp_grant[%0d]: got %b expected 01", c, rdy[1]);
            end
            checks++;
            if (rdy[0] !== exp_grant(0)) begin
                errors++;
                $display("FAIL fp_rr_side[%0d]: got %b expected %b", c, rdy[0], exp_grant(0));
            end
            if (c > 0) begin
                checks++;
                if (rd[1][0] !== prev0) begin
                    errors++;
                    $display("FAIL fp_resp[%0d]: got %h expected %h", c, rd[1][0], prev0);
                end
            end
            prev0 = ref_shift(req_a[0], req_shamt[0], req_type[0]);
        end
        @(negedge clk);
        req_valid = 2'b10;
        p1_exp = ref_shift(req_a[1], req_shamt[1], req_type[1]);
        #1;
        checks++;
        if (rdy[1] !== 2'b10) begin
            errors++;
            $display("FAIL fp_release: got %b expected 10", rdy[1]);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (rv[1] !== 2'b10 || rd[1][1] !== p1_exp) begin
            errors++;
            $display("FAIL fp_port1_resp: got %b/%h expected 10/%h", rv[1], rd[1][1], p1_exp);
        end
    endtask

    task automatic test_random();
        logic [1:0] g_prev = 2'b00;
        do_reset();
        rand_op(0);
        rand_op(1);
        req_valid = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            // A pending (valid, not granted) request keeps its operands.
            for (int p = 0; p < 2; p++) begin
                if (!(req_valid[p] && !g_prev[p])) begin
                    req_valid[p] = ($urandom_range(0, 3) != 0);
                    rand_op(p);
                end
            end
            resp_ready = 2'($urandom_range(0, 3));
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdy[k] !== exp_grant(k)) begin
                    errors++;
                    $display("FAIL rand_ready k%0d c%0d: got %b expected %b",
                             k, c, rdy[k], exp_grant(k));
                end
                checks++;
                if (rv[k] !== m_v[k] || rd[k][0] !== m_d[k][0] || rd[k][1] !== m_d[k][1]) begin
                    errors++;
                    $display("FAIL rand_resp k%0d c%0d: got %b %h/%h expected %b %h/%h",
                             k, c, rv[k], rd[k][0], rd[k][1], m_v[k], m_d[k][0], m_d[k][1]);
                end
                checks++;
                if ({sh_a[k], sh_s[k], sh_t[k]} !== exp_drive(k)) begin
                    errors++;
                    $display("FAIL rand_drive k%0d c%0d: got %h expected %h",
                             k, c, {sh_a[k], sh_s[k], sh_t[k]}, exp_drive(k));
                end
            end
            g_prev = exp_grant(0);
        end
    endtask

    initial begin
        req_valid = 2'b00;
        resp_ready = 2'b11;
        rand_op(0);
        rand_op(1);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain_refill();
        test_reset_mid();
        test_fixed_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single combinational 32-bit barrel shifter between two requesters, the execute-stage ALU (port 0) and the CSR/immediate-generation path (port 1). Each cycle it grants at most one requester through a valid/ready handshake and drives that request's operands onto the shifter. It captures the shifter result in a per-requester response register and returns it with a valid/ready handshake. The arbiter only routes operands and results; it never interprets the shift type.

## Interface
- FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins contention
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- req0_valid / req1_valid  in  1  request present on port i
- req0_ready / req1_ready  out  1  port i request accepted this cycle when valid&ready
- req0_a / req1_a  in  32  operand to shift
- req0_shamt / req1_shamt  in  5  shift amount
- req0_type / req1_type  in  2  shift type: 00 logical right, 01 left, 10 arithmetic right, 11 pass-through
- resp0_valid / resp1_valid  out  1  result held for port i
- resp0_ready / resp1_ready  in  1  port i consumes result when valid&ready
- resp0_data / resp1_data  out  32  shift result for port i
- sh_a  out  32  operand driven to the shifter
- sh_shamt  out  5  shift amount driven to the shifter
- sh_type  out  2  type driven to the shifter
- sh_r  in  32  combinational shifter result

## Operation
- slot_free_i = !resp_i_valid || resp_i_ready. A response slot that drains this cycle can be refilled in the same cycle.
- eligible_i = req_i_valid && slot_free_i.
- Grant, at most one per cycle:
  - If only one port is eligible, that port is granted.
  - If both are eligible, the priority holder is granted. prio_ptr is a 1-bit register; when FIXED_PRIORITY=1, prio is held at 0.
- req_i_ready = grant_i. Ready is combinational from both ports' valids and the slot state. It is never asserted while that port's slot is occupied and not draining.
- Shifter drive:
  - When a port is granted, sh_a/sh_shamt/sh_type carry that port's request.
  - When no port is granted, the drive is 0 / 0 / 2'b11 (idle pass of zero).
- On grant_i: resp_i_data <= sh_r and resp_i_valid <= 1.
- On resp_i_valid && resp_i_ready with no new grant_i: resp_i_valid <= 0. resp_i_data holds its last value.
- Round-robin (FIXED_PRIORITY=0):
  - After any grant to port i, prio_ptr <= ~i.
  - With no grant, prio_ptr holds.
- Requests are not buffered. A port that is not granted must hold its valid and operands stable until ready, per the standard handshake.
- Result registers are independent. Port 1 may be granted while port 0 holds an unconsumed result.

## Timing
- Reset (rst_n low at a rising edge):
  - resp0_valid = resp1_valid = 0.
  - resp0_data = resp1_data = 0.
  - prio_ptr = 0.
  - Pending responses are discarded; nothing is granted during that cycle.
- req_i_ready is forced to 0 while rst_n is low.
- Latency:
  - A request accepted at edge N produces resp_i_valid=1 from edge N onward, i.e. visible in cycle N+1. This is one cycle of latency.
- Throughput:
  - Peak is one shift per cycle across both ports.
  - A single port sustains one per cycle while its resp_ready stays high.
- Backpressure: with resp_i_valid=1 and resp_i_ready=0, req_i_ready=0. The slot holds its data unchanged for any number of cycles.
- Simultaneous drain and accept on the same port, in the same cycle: the old result is consumed and the new result is loaded, so resp_i_valid stays 1.
- Both ports eligible every cycle (round-robin): grants alternate 0,1,0,1… starting with port 0 after reset.
- The combinational path is sh_r to the resp_data register only; there is no path from sh_r to any output in the same cycle.

## Test plan
- Single request:
  - Stimulus: port 0, a=32'h8000_0001, shamt=4, type=01.
  - Response: req0_ready=1 in the same cycle; next cycle resp0_valid=1 with resp0_data=32'h0000_0010. Pass type 11 with a=32'hDEAD_BEEF returns 32'hDEAD_BEEF.
- Contention, round-robin:
  - Stimulus: both ports valid for 4 cycles, both resp_ready=1.
  - Response: grants in order 0,1,0,1. Each result appears one cycle after its grant, on the correct port.
- Backpressure:
  - Stimulus: port 0 result held with resp0_ready=0 for 5 cycles while both ports request.
  - Response: port 1 is granted every cycle; req0_ready=0 throughout; resp0_data is unchanged.
- Drain and refill:
  - Stimulus: resp0_valid=1 and resp0_ready=1 while a new port-0 request is valid.
  - Response: the request is accepted that cycle and resp0_valid stays 1 with the new data, with no bubble.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge while both responses are valid.
  - Response: both resp_valid=0 and resp_data=0 afterwards; the next contention is granted to port 0 first.
- FIXED_PRIORITY=1:
  - Stimulus: both ports continuously valid, both resp_ready=1.
  - Response: port 0 wins every cycle and port 1 is never granted until port 0 drops valid.
